// File: rtl/contador_mod_7seg_if.sv
// Control/load bus and display outputs of the two-digit BCD modulo counter.
// master drives requests and observes the count; slave is the counter itself.
interface contador_mod_7seg_if;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [BCD_W-1:0] load_dez;
  logic [BCD_W-1:0] load_uni;
  logic [BCD_W-1:0] bcd_dez;
  logic [BCD_W-1:0] bcd_uni;
  logic [SEG_W-1:0] seg_dez;
  logic [SEG_W-1:0] seg_uni;
  logic             carry;
  logic             err;

  modport master (
    output en, up, clr, load, load_dez, load_uni,
    input  bcd_dez, bcd_uni, seg_dez, seg_uni, carry, err
  );

  modport slave (
    input  en, up, clr, load, load_dez, load_uni,
    output bcd_dez, bcd_uni, seg_dez, seg_uni, carry, err
  );
endinterface

// File: rtl/contador_mod_7seg.sv
// Two-digit BCD up/down modulo counter with clear/load and registered
// 7-segment encoding of both digits; carry pulses on wrap or borrow.
module contador_mod_7seg #(
  parameter int unsigned MODULO          = 60,
  parameter bit          SEG_ATIVO_BAIXO = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  contador_mod_7seg_if.slave bus
);
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned VAL_W   = 8;
  localparam logic [BCD_W-1:0] MAX_DEZ = BCD_W'((MODULO - 1) / 10);
  localparam logic [BCD_W-1:0] MAX_UNI = BCD_W'((MODULO - 1) % 10);
  localparam logic [BCD_W-1:0] NINE    = BCD_W'(9);

  // BCD digit to segments (g..a), polarity applied for common-anode displays
  function automatic logic [SEG_W-1:0] seg_code(input logic [BCD_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return SEG_ATIVO_BAIXO ? ~s : s;
  endfunction

  localparam logic [SEG_W-1:0] SEG_ZERO = seg_code(4'd0);

  logic [BCD_W-1:0] next_dez;
  logic [BCD_W-1:0] next_uni;
  logic             next_carry;
  logic             next_err;
  logic [VAL_W-1:0] load_val;
  logic             load_ok;
  logic             at_max;
  logic             at_zero;

  // Next count, carry and err with clr > load > en priority
  always_comb begin
    next_dez   = bus.bcd_dez;
    next_uni   = bus.bcd_uni;
    next_carry = 1'b0;
    next_err   = 1'b0;

    load_val = VAL_W'(bus.load_dez) * VAL_W'(10) + VAL_W'(bus.load_uni);
    load_ok  = (bus.load_dez <= NINE) && (bus.load_uni <= NINE) &&
               (load_val < VAL_W'(MODULO));
    at_max   = (bus.bcd_dez == MAX_DEZ) && (bus.bcd_uni == MAX_UNI);
    at_zero  = (bus.bcd_dez == '0) && (bus.bcd_uni == '0);

    if (bus.clr) begin
      next_dez = '0;
      next_uni = '0;
    end else if (bus.load) begin
      if (load_ok) begin
        next_dez = bus.load_dez;
        next_uni = bus.load_uni;
      end else begin
        next_err = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_max) begin
          next_dez   = '0;
          next_uni   = '0;
          next_carry = 1'b1;
        end else if (bus.bcd_uni == NINE) begin
          next_uni = '0;
          next_dez = bus.bcd_dez + BCD_W'(1);
        end else begin
          next_uni = bus.bcd_uni + BCD_W'(1);
        end
      end else begin
        if (at_zero) begin
          next_dez   = MAX_DEZ;
          next_uni   = MAX_UNI;
          next_carry = 1'b1;
        end else if (bus.bcd_uni == '0) begin
          next_uni = NINE;
          next_dez = bus.bcd_dez - BCD_W'(1);
        end else begin
          next_uni = bus.bcd_uni - BCD_W'(1);
        end
      end
    end
  end

  // Segments encoded from the next-state digits so they track bcd_* exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bcd_dez <= '0;
      bus.bcd_uni <= '0;
      bus.seg_dez <= SEG_ZERO;
      bus.seg_uni <= SEG_ZERO;
      bus.carry   <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.bcd_dez <= next_dez;
      bus.bcd_uni <= next_uni;
      bus.seg_dez <= seg_code(next_dez);
      bus.seg_uni <= seg_code(next_uni);
      bus.carry   <= next_carry;
      bus.err     <= next_err;
    end
  end
endmodule
